hack_data_mem_io: RTL
=====================

# hack_data_mem_io

Data-memory and I/O responder for the Hack CPU's M-port (`addressM`/`outM`/`writeM` in, `inM` out). It is the memory side of the interface the CPU core drives.
- Serves a 16K-word data RAM and a small memory-mapped I/O page: LEDs, synchronized switches, a cycle counter, and an output FIFO drained by an external valid/ready consumer.
- `inM` is combinational from `addressM`, matching the CPU's single-cycle read expectation. All state updates occur on the rising clock edge.

## Interface
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, 2–16.
- `SW_WIDTH`, 8: number of switch inputs.
- `LED_WIDTH`, 8: number of LED outputs.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addressM`  in  15  CPU data address.
- `outM`  in  16  CPU write data.
- `writeM`  in  1  CPU write strobe.
- `inM`  out  16  read data for `addressM`; combinational.
- `sw`  in  SW_WIDTH  asynchronous switch inputs.
- `led`  out  LED_WIDTH  LED register, low bits.
- `tx_data`  out  16  FIFO head word.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head word.

## Operation
Address map. Unlisted addresses read 0x0000 and ignore writes.
- 0x0000–0x3FFF RAM, 16384×16.
  - Write: `mem[addressM] <= outM` when `writeM`.
  - Read: asynchronous.
  - Contents are not reset.
- 0x4000–0x5FFF: reserved screen window; reads 0, writes ignored.
- 0x6000 LED: read/write. Reads return the register zero-extended; writes store `outM[LED_WIDTH-1:0]`.
- 0x6001 SW: read-only. Returns the 2-flop synchronized `sw`, zero-extended.
- 0x6002 CNT: free-running 16-bit counter, +1 per clock, wraps 0xFFFF→0x0000.
  - Any write clears it to 0; the clear wins over the increment.
- 0x6003 FIFO data: a write pushes `outM`; reads return 0.
- 0x6004 FIFO status, read-only except bit 15:
  - bit0 full, bit1 empty, bits[6:2] count (0..FIFO_DEPTH), bit15 sticky overflow.
  - A write (any data) clears overflow.

FIFO behaviour:
- Storage: circular buffer with read/write pointers and a count register.
- Outputs: `tx_valid` = count≠0; `tx_data` = entry at the read pointer.
- Pop occurs when `tx_valid && tx_ready`.
- Push is accepted when count<FIFO_DEPTH, or when full with a pop in the same cycle.
  - In the full case the count stays at FIFO_DEPTH, both pointers advance, and no overflow is flagged.
- Push while full without a pop: the data is dropped and overflow is set; pointers and count are unchanged.
- Push into an empty FIFO: no pop that cycle (`tx_valid` was low); count becomes 1.
- Pointers wrap modulo FIFO_DEPTH.

Reset, synchronous:
- `led`=0, CNT=0, sync flops=0.
- FIFO empty, pointers 0, overflow=0.
- `tx_valid`=0.
- `inM` is the combinational read of the reset state.
- RAM is untouched; reset mid-operation discards FIFO contents.

## Timing
- Read latency 0: `inM` reflects `addressM` and current state in the same cycle.
- A write to address X is visible to reads of X from the cycle after the write edge. A same-cycle read returns the old value.
- CNT reads 0 in the first cycle after reset deasserts, then N after N further edges.
- A CNT write at edge k gives 0 in the following cycle and 1 one cycle later.
- SW: a change on `sw` before edge k is readable after edge k+1 (2-cycle synchronizer).
- FIFO: a push at edge k raises `tx_valid` and presents `tx_data` after edge k. A pop at edge k updates `tx_data` and `tx_valid` after edge k.
- Status updates one edge after the causing push, pop or clear.

## Test plan
- RAM:
  - Write 0x1234→0x0005 and 0xABCD→0x3FFF, then read both back: 0x1234 and 0xABCD.
  - Read 0x4000 after writing 0xFFFF to it: 0x0000.
- LED/SW:
  - Write 0x00A5 to 0x6000: `led`=0xA5, read 0x00A5.
  - Set `sw`=0x3C: read 0x6001 shows 0x003C two cycles later, not earlier.
- CNT:
  - Release reset and read 0x6002 each cycle: 0,1,2,…
  - Write 0x6002 at cycle 10: next read 0, then 1.
  - Force the value to 0xFFFF via an extended run: it wraps to 0x0000.
- FIFO fill/overflow:
  - With `tx_ready`=0, push 1..9: status shows full=1, count=8, overflow=1; `tx_data`=1.
  - Write 0x6004: overflow clears.
  - Drain with `tx_ready`=1: the words appear as 1..8 in order, then empty=1, `tx_valid`=0.
- FIFO simultaneous: with the FIFO full and `tx_ready`=1, push 0x0042: count stays 8, no overflow, and 0x0042 emerges last.
- Reset mid-operation: with 5 words queued and LED=0xFF, pulse `reset` for one cycle: `tx_valid`=0, count=0, `led`=0, CNT=0. RAM location 0x0005 still reads 0x1234.

Source files
------------

// File: rtl/hack_data_mem_io.sv
// hack_data_mem_io: Hack CPU data RAM plus LED/switch/counter/output-FIFO I/O page
module hack_data_mem_io #(
  parameter int FIFO_DEPTH = 8,
  parameter int SW_WIDTH = 8,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [14:0]          addressM,
  input  logic [15:0]          outM,
  input  logic                 writeM,
  output logic [15:0]          inM,
  input  logic [SW_WIDTH-1:0]  sw,
  output logic [LED_WIDTH-1:0] led,
  output logic [15:0]          tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [15:0] mem [16384];
  logic [15:0] fifo [FIFO_DEPTH];
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0] sw1_q, sw2_q;
  logic [15:0] tick_q, tick_d, stat;
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, io, wr_led, wr_tick, wr_fifo, wr_stat, full, pop, push;
  always_comb begin
    io = addressM[14:3] == 12'hC00;
    wr_led = writeM && io && addressM[2:0] == 3'd0;
    wr_tick = writeM && io && addressM[2:0] == 3'd2;
    wr_fifo = writeM && io && addressM[2:0] == 3'd3;
    wr_stat = writeM && io && addressM[2:0] == 3'd4;
    full = cnt_q == CW'(FIFO_DEPTH);
    pop = cnt_q != '0 && tx_ready;
    push = wr_fifo && (!full || pop);
    led_d = wr_led ? outM[LED_WIDTH-1:0] : led_q;
    tick_d = wr_tick ? 16'd0 : tick_q + 16'd1;
    ovf_d = wr_stat ? 1'b0 : (wr_fifo && full && !pop) ? 1'b1 : ovf_q;
    cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    stat = {ovf_q, 8'd0, 5'(cnt_q), cnt_q == '0, full};
    inM = !addressM[14] ? mem[addressM[13:0]] :
          !io ? 16'd0 :
          addressM[2:0] == 3'd0 ? 16'(led_q) :
          addressM[2:0] == 3'd1 ? 16'(sw2_q) :
          addressM[2:0] == 3'd2 ? tick_q :
          addressM[2:0] == 3'd4 ? stat : 16'd0;
    led = led_q;
    tx_valid = cnt_q != '0;
    tx_data = fifo[rp_q];
  end
  always_ff @(posedge clk) begin
    if (writeM && !addressM[14]) mem[addressM[13:0]] <= outM;
    if (push) fifo[wp_q] <= outM;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
      tick_q <= '0;
      rp_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      sw1_q <= sw;
      sw2_q <= sw1_q;
      tick_q <= tick_d;
      rp_q <= rp_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
